// File: rtl/obstacle_scheduler.sv
// Run-time controller for scrolling obstacle pairs: scroll tick, slot spawn/retire,
// speed-up schedule, score and collision-driven endgame.
module obstacle_scheduler #(
    parameter int unsigned N_SLOTS        = 3,
    parameter int unsigned SPAWN_X        = 750,
    parameter int unsigned TICK_DIV_INIT  = 4_000_000,
    parameter int unsigned TICK_DIV_MIN   = 1_000_000,
    parameter int unsigned DIV_STEP       = 250_000,
    parameter int unsigned SPAWN_TICKS    = 250,
    parameter int unsigned SPEEDUP_SPAWNS = 4,
    parameter int unsigned GAP_Y_MIN      = 100,
    parameter int unsigned GAP_H          = 150,
    parameter int unsigned PLAYER_X_MAX   = 64,
    parameter int unsigned H_OF_REC       = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [11:0]               player_ypos,
    output logic                      tick,
    output logic [N_SLOTS-1:0]        slot_active,
    output logic [12*N_SLOTS-1:0]     slot_xpos,
    output logic [12*N_SLOTS-1:0]     slot_gap_y,
    output logic [9:0]                score,
    output logic                      endgame
);

    localparam int unsigned DIV_W     = $clog2(TICK_DIV_INIT + 1);
    localparam int unsigned SPW       = $clog2(SPAWN_TICKS + 1);
    localparam int unsigned SNW       = $clog2(SPEEDUP_SPAWNS + 1);
    localparam int unsigned SCORE_MAX = 999;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

    state_t                  state, state_nx;
    logic                    tick_nx, endgame_nx;
    logic [N_SLOTS-1:0]      active_nx;
    logic [12*N_SLOTS-1:0]   xpos_nx, gap_nx;
    logic [9:0]              score_nx;
    logic [DIV_W-1:0]        div_cnt, div_cnt_nx, cur_div, cur_div_nx;
    logic [SPW-1:0]          spawn_cnt, spawn_cnt_nx;
    logic [SNW-1:0]          spawn_num, spawn_num_nx;
    logic [7:0]              lfsr, lfsr_nx;
    logic                    hit, tick_evt, spawn_due, spawn_ok;
    logic [N_SLOTS-1:0]      spawn_oh;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tick        <= 1'b0;
            slot_active <= '0;
            slot_xpos   <= '0;
            slot_gap_y  <= '0;
            score       <= '0;
            endgame     <= 1'b0;
            div_cnt     <= '0;
            cur_div     <= DIV_W'(TICK_DIV_INIT);
            spawn_cnt   <= '0;
            spawn_num   <= '0;
            lfsr        <= 8'hA5;
        end else begin
            state       <= state_nx;
            tick        <= tick_nx;
            slot_active <= active_nx;
            slot_xpos   <= xpos_nx;
            slot_gap_y  <= gap_nx;
            score       <= score_nx;
            endgame     <= endgame_nx;
            div_cnt     <= div_cnt_nx;
            cur_div     <= cur_div_nx;
            spawn_cnt   <= spawn_cnt_nx;
            spawn_num   <= spawn_num_nx;
            lfsr        <= lfsr_nx;
        end
    end

    // Player rectangle outside the gap of any active slot in the player column
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (slot_active[i] && (slot_xpos[12*i +: 12] <= 12'(PLAYER_X_MAX)) &&
                ((13'(player_ypos) < 13'(slot_gap_y[12*i +: 12])) ||
                 (13'(player_ypos) + 13'(H_OF_REC) > 13'(slot_gap_y[12*i +: 12]) + 13'(GAP_H))))
                hit = 1'b1;
        end
    end

    assign tick_evt  = (state == RUN) && !hit && (div_cnt == cur_div - DIV_W'(1));
    assign spawn_due = (spawn_cnt == SPW'(SPAWN_TICKS - 1));
    // Lowest clear bit of slot_active; zero when every slot is busy
    assign spawn_oh  = ~slot_active & (slot_active + N_SLOTS'(1));
    assign spawn_ok  = spawn_due && (|spawn_oh);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (hit)   state_nx = OVER;
            OVER:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tick_nx      = 1'b0;
        active_nx    = slot_active;
        xpos_nx      = slot_xpos;
        gap_nx       = slot_gap_y;
        score_nx     = score;
        endgame_nx   = endgame;
        div_cnt_nx   = div_cnt;
        cur_div_nx   = cur_div;
        spawn_cnt_nx = spawn_cnt;
        spawn_num_nx = spawn_num;
        lfsr_nx      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        case (state)
            IDLE, OVER: begin
                // Fresh game; spawn counter preset so the first tick spawns
                if (start) begin
                    active_nx    = '0;
                    xpos_nx      = '0;
                    gap_nx       = '0;
                    score_nx     = '0;
                    endgame_nx   = 1'b0;
                    div_cnt_nx   = '0;
                    cur_div_nx   = DIV_W'(TICK_DIV_INIT);
                    spawn_cnt_nx = SPW'(SPAWN_TICKS - 1);
                    spawn_num_nx = '0;
                end
            end
            RUN: begin
                if (hit) begin
                    endgame_nx = 1'b1;
                end else begin
                    div_cnt_nx = tick_evt ? '0 : div_cnt + DIV_W'(1);
                    if (tick_evt) begin
                        tick_nx      = 1'b1;
                        spawn_cnt_nx = spawn_due ? '0 : spawn_cnt + SPW'(1);
                        for (int i = 0; i < int'(N_SLOTS); i++) begin
                            if (slot_active[i]) begin
                                if (slot_xpos[12*i +: 12] == 12'd0) begin
                                    active_nx[i] = 1'b0;
                                    if (score_nx != 10'(SCORE_MAX))
                                        score_nx = score_nx + 10'd1;
                                end else begin
                                    xpos_nx[12*i +: 12] = slot_xpos[12*i +: 12] - 12'd1;
                                end
                            end
                            if (spawn_ok && spawn_oh[i]) begin
                                active_nx[i]        = 1'b1;
                                xpos_nx[12*i +: 12] = 12'(SPAWN_X);
                                gap_nx[12*i +: 12]  = 12'(GAP_Y_MIN) + 12'(lfsr);
                            end
                        end
                        if (spawn_ok) begin
                            if (spawn_num == SNW'(SPEEDUP_SPAWNS - 1)) begin
                                spawn_num_nx = '0;
                                cur_div_nx   = (32'(cur_div) >= TICK_DIV_MIN + DIV_STEP) ?
                                               cur_div - DIV_W'(DIV_STEP) : DIV_W'(TICK_DIV_MIN);
                            end else begin
                                spawn_num_nx = spawn_num + SNW'(1);
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: directed tick-indexed table, collision/restart/reset
// sequences, and randomized play checked every cycle against a timeline model.
module tb_obstacle_scheduler;

    localparam int unsigned N           = 3;
    localparam int unsigned SPAWN_X     = 20;
    localparam int unsigned DIV_INIT    = 4;
    localparam int unsigned DIV_MIN     = 2;
    localparam int unsigned DIV_STEP    = 1;
    localparam int unsigned SPAWN_TICKS = 3;
    localparam int unsigned SPEEDUP     = 2;
    localparam int unsigned GAP_Y_MIN   = 100;
    localparam int unsigned GAP_H       = 150;
    localparam int unsigned PX_MAX      = 2;
    localparam int unsigned H_REC       = 20;

    logic          clk, rst_n, start;
    logic [11:0]   player_ypos;
    logic          tick;
    logic [N-1:0]  slot_active;
    logic [35:0]   slot_xpos, slot_gap_y;
    logic [9:0]    score;
    logic          endgame;

    obstacle_scheduler #(
        .N_SLOTS(N), .SPAWN_X(SPAWN_X), .TICK_DIV_INIT(DIV_INIT), .TICK_DIV_MIN(DIV_MIN),
        .DIV_STEP(DIV_STEP), .SPAWN_TICKS(SPAWN_TICKS), .SPEEDUP_SPAWNS(SPEEDUP),
        .GAP_Y_MIN(GAP_Y_MIN), .GAP_H(GAP_H), .PLAYER_X_MAX(PX_MAX), .H_OF_REC(H_REC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .player_ypos(player_ypos),
        .tick(tick), .slot_active(slot_active), .slot_xpos(slot_xpos),
        .slot_gap_y(slot_gap_y), .score(score), .endgame(endgame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: ticks scheduled by absolute edge number, spawns by tick number
    typedef struct packed {
        logic              running;
        logic              tick;
        logic              endgame;
        logic [2:0]        active;
        logic [2:0][11:0]  xpos;
        logic [2:0][11:0]  gap;
        logic [9:0]        score;
        logic [7:0]        lfsr;
        logic [31:0]       edge_no;
        logic [31:0]       next_tick_at;
        logic [31:0]       period;
        logic [31:0]       tick_no;
        logic [31:0]       spawns;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.lfsr   = 8'hA5;
        r.period = 32'(DIV_INIT);
        return r;
    endfunction

    function automatic model_t next_model(model_t c, logic st, logic [11:0] py);
        model_t n;
        bit     crash;
        int     free;
        n = c;
        n.edge_no = c.edge_no + 1;
        n.lfsr    = {c.lfsr[6:0], c.lfsr[7] ^ c.lfsr[5] ^ c.lfsr[4] ^ c.lfsr[3]};
        n.tick    = 1'b0;
        if (c.running) begin
            crash = 1'b0;
            for (int i = 0; i < 3; i++) begin
                int top = int'(c.gap[i]);
                if (c.active[i] && int'(c.xpos[i]) <= int'(PX_MAX) &&
                    (int'(py) < top || int'(py) + int'(H_REC) > top + int'(GAP_H)))
                    crash = 1'b1;
            end
            if (crash) begin
                n.running = 1'b0;
                n.endgame = 1'b1;
            end else if (n.edge_no == c.next_tick_at) begin
                n.tick    = 1'b1;
                n.tick_no = c.tick_no + 1;
                for (int i = 0; i < 3; i++) begin
                    if (c.active[i]) begin
                        if (c.xpos[i] == 12'd0) begin
                            n.active[i] = 1'b0;
                            if (n.score < 10'd999) n.score = n.score + 10'd1;
                        end else begin
                            n.xpos[i] = c.xpos[i] - 12'd1;
                        end
                    end
                end
                if ((n.tick_no - 1) % SPAWN_TICKS == 0) begin
                    free = -1;
                    for (int i = 2; i >= 0; i--) if (!c.active[i]) free = i;
                    if (free >= 0) begin
                        n.active[free] = 1'b1;
                        n.xpos[free]   = 12'(SPAWN_X);
                        n.gap[free]    = 12'(GAP_Y_MIN + int'(c.lfsr));
                        n.spawns       = c.spawns + 1;
                        if (n.spawns % SPEEDUP == 0)
                            n.period = (c.period >= DIV_MIN + DIV_STEP) ? c.period - DIV_STEP : DIV_MIN;
                    end
                end
                n.next_tick_at = n.edge_no + n.period;
            end
        end else if (st) begin
            n              = model_reset();
            n.lfsr         = {c.lfsr[6:0], c.lfsr[7] ^ c.lfsr[5] ^ c.lfsr[4] ^ c.lfsr[3]};
            n.edge_no      = c.edge_no + 1;
            n.running      = 1'b1;
            n.next_tick_at = n.edge_no + DIV_INIT;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= next_model(m, start, player_ypos);
    end

    int total, bad, cyc;
    bit safe;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // One cycle: sample at negedge, compare to model, keep player inside the gap if asked
    task automatic step();
        logic [86:0] got, want;
        @(negedge clk);
        cyc++;
        got  = {tick, slot_active, slot_xpos, slot_gap_y, score, endgame};
        want = {m.tick, m.active, m.xpos, m.gap, m.score, m.endgame};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL scoreboard cyc=%0d got=%h expected=%h", cyc, got, want);
        end
        if (safe)
            for (int i = 0; i < 3; i++)
                if (m.active[i] && m.xpos[i] <= 12'(PX_MAX)) player_ypos = m.gap[i] + 12'd50;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no tick expected tick within 40 cycles");
        end
    endtask

    typedef struct {
        int         tick_no;
        int         period;
        logic [2:0] act;
        int         x0, x1, x2;
        int         score;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int  tno, prev, per, seen;
        bit  ok;

        tbl[0]  = '{1,  4, 3'b001, 20,  0,  0, 0};
        tbl[1]  = '{2,  4, 3'b001, 19,  0,  0, 0};
        tbl[2]  = '{4,  4, 3'b011, 17, 20,  0, 0};
        tbl[3]  = '{5,  3, 3'b011, 16, 19,  0, 0};
        tbl[4]  = '{7,  3, 3'b111, 14, 17, 20, 0};
        tbl[5]  = '{10, 3, 3'b111, 11, 14, 17, 0};
        tbl[6]  = '{21, 3, 3'b111,  0,  3,  6, 0};
        tbl[7]  = '{22, 3, 3'b110,  0,  2,  5, 1};
        tbl[8]  = '{25, 3, 3'b101, 20,  0,  2, 2};
        tbl[9]  = '{26, 2, 3'b101, 19,  0,  1, 2};
        tbl[10] = '{28, 2, 3'b011, 17, 20,  0, 3};
        tbl[11] = '{32, 2, 3'b111, 13, 16, 19, 3};

        total = 0; bad = 0; cyc = 0; safe = 1'b0;
        rst_n = 1'b0; start = 1'b0; player_ypos = 12'd200;
        step(); step();
        check("reset_tick",    64'(tick),        64'd0);
        check("reset_active",  64'(slot_active), 64'd0);
        check("reset_xpos",    64'(slot_xpos),   64'd0);
        check("reset_gap",     64'(slot_gap_y),  64'd0);
        check("reset_score",   64'(score),       64'd0);
        check("reset_endgame", 64'(endgame),     64'd0);
        rst_n = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        safe = 1'b1;

        // Spawn cadence, dropped attempts, retire/reuse and speed-up floor
        tno = 0; prev = cyc; per = 0; ok = 1'b1;
        for (int k = 0; k < 12 && ok; k++) begin
            while (tno < tbl[k].tick_no && ok) begin
                wait_tick(ok);
                tno++;
                per  = cyc - prev;
                prev = cyc;
            end
            if (ok) begin
                check($sformatf("T%0d_period", tbl[k].tick_no), 64'(per), 64'(tbl[k].period));
                check($sformatf("T%0d_state", tbl[k].tick_no),
                      {25'd0, slot_active, slot_xpos[35:24], slot_xpos[23:12], slot_xpos[11:0]},
                      {25'd0, tbl[k].act, 12'(tbl[k].x2), 12'(tbl[k].x1), 12'(tbl[k].x0)});
                check($sformatf("T%0d_score", tbl[k].tick_no), 64'(score), 64'(tbl[k].score));
            end
        end

        // Player hugs the top edge as slot0 reaches the player column
        safe = 1'b0; player_ypos = 12'd0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick && slot_xpos[11:0] == 12'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check("col_reached", 64'(ok), 64'd1);
        check("col_endgame_pre", 64'(endgame), 64'd0);
        step();
        check("col_endgame", 64'(endgame), 64'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tick) seen++;
        end
        check("over_ticks", 64'(seen), 64'd0);
        check("over_frozen", {25'd0, slot_active, slot_xpos}, {25'd0, 3'b111, 12'd8, 12'd5, 12'd2});
        check("over_endgame", 64'(endgame), 64'd1);

        // Restart from OVER
        player_ypos = 12'd200;
        start = 1'b1; step(); start = 1'b0;
        safe = 1'b1;
        check("restart_score",   64'(score),       64'd0);
        check("restart_active",  64'(slot_active), 64'd0);
        check("restart_endgame", 64'(endgame),     64'd0);
        prev = cyc;
        wait_tick(ok);
        check("restart_period", 64'(cyc - prev), 64'd4);
        check("restart_slot0", {51'd0, slot_active, slot_xpos[11:0]}, {51'd0, 3'b001, 12'd20});

        // Asynchronous reset in the middle of a run
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_tick",    64'(tick),        64'd0);
        check("arst_active",  64'(slot_active), 64'd0);
        check("arst_xpos",    64'(slot_xpos),   64'd0);
        check("arst_gap",     64'(slot_gap_y),  64'd0);
        check("arst_score",   64'(score),       64'd0);
        check("arst_endgame", 64'(endgame),     64'd0);
        step();
        rst_n = 1'b1;

        // Randomized play against the model
        for (int i = 0; i < 20000; i++) begin
            if (i % 64 == 0) safe = ($urandom_range(0, 9) != 0);
            start = ($urandom_range(0, 24) == 0);
            if (!safe) player_ypos = 12'($urandom_range(0, 450));
            if ($urandom_range(0, 1999) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
